// File: rtl/fb_pkg.sv
// Shared constants for the frame buffer controller: default geometry,
// output FIFO depth and controller state encoding.
package fb_pkg;

    localparam int FB_DATA_W       = 8;
    localparam int FB_FRAME_PIXELS = 307200;
    localparam int FB_ADDR_W       = 19;
    localparam int FB_RD_LAT       = 2;
    localparam int FB_FIFO_DEPTH   = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

endpackage

// File: rtl/fb_out_fifo.sv
// Four-entry first-word-fall-through FIFO carrying {last, pixel} between the
// BRAM read pipeline and the downstream handshake.
module fb_out_fifo
    import fb_pkg::*;
#(
    parameter int WIDTH = FB_DATA_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [2:0]       count
);

    localparam logic [2:0] DEPTH = 3'(FB_FIFO_DEPTH);

    logic [WIDTH-1:0] mem [0:FB_FIFO_DEPTH-1];
    logic [1:0]       wr_ptr_reg;
    logic [1:0]       rd_ptr_reg;
    logic [2:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != 3'd0);
    // A push into a full FIFO is only taken when the head leaves the same cycle.
    assign do_push = push && ((count_reg != DEPTH) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign valid = (count_reg != 3'd0);
    assign count = count_reg;

endmodule

// File: rtl/frame_buf_ctrl.sv
// Single-frame buffer controller: captures one frame into a dual-port BRAM on
// port A, then streams it back out of port B through a small credit-limited FIFO.
module frame_buf_ctrl
    import fb_pkg::*;
#(
    parameter int DATA_W       = FB_DATA_W,
    parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int RD_LAT       = FB_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              rd_start,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              enb,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic              regceb,
    output logic              rstb,
    input  logic [DATA_W-1:0] doutb,
    output logic              frame_done,
    output logic              rd_done,
    output logic              sof_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [ADDR_W:0]   RD_END    = (ADDR_W + 1)'(FRAME_PIXELS);
    localparam logic [ADDR_W:0]   RD_LAST   = (ADDR_W + 1)'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W:0]   ONE_R     = (ADDR_W + 1)'(1);
    localparam logic [4:0]        CREDITS   = 5'(FB_FIFO_DEPTH);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_addr_reg;
    // One spare bit so the read pointer can sit one past the last pixel.
    logic [ADDR_W:0]   rd_addr_reg;
    logic [RD_LAT-1:0] vld_sr_reg;
    logic [RD_LAT-1:0] last_sr_reg;
    logic              frame_done_reg;
    logic              rd_done_reg;
    logic              sof_err_reg;

    logic              accept;
    logic              wr_en;
    logic              wr_to_zero;
    logic              wr_last;
    logic              issue;
    logic              pop;
    logic              last_pop;
    logic [3:0]        inflight;
    logic [2:0]        fifo_count;
    logic              fifo_valid;
    logic [DATA_W:0]   fifo_dout;

    // ---------------- write side ----------------
    assign s_ready = !rst && ((state_reg == ST_IDLE) || (state_reg == ST_WRITE));
    assign accept  = s_valid && s_ready;

    always_comb begin
        wr_en      = 1'b0;
        wr_to_zero = 1'b0;
        if (accept) begin
            if (s_sof) begin
                wr_en      = 1'b1;
                wr_to_zero = 1'b1;
            end else if (state_reg == ST_WRITE) begin
                wr_en = 1'b1;
            end
        end
    end

    assign wr_last = (state_reg == ST_WRITE) && accept && !s_sof && (wr_addr_reg == LAST_ADDR);

    assign ena   = wr_en;
    assign wea   = wr_en;
    assign addra = (wr_en && !wr_to_zero) ? wr_addr_reg : '0;
    assign dina  = wr_en ? s_data : '0;

    // ---------------- read side ----------------
    always_comb begin
        inflight = 4'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 4'(vld_sr_reg[i]);
        end
    end

    // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign issue = !rst && (state_reg == ST_READ) && (rd_addr_reg < RD_END)
                   && (({1'b0, inflight} + {2'b00, fifo_count}) < CREDITS);

    assign enb    = issue;
    assign web    = 1'b0;
    assign addrb  = issue ? rd_addr_reg[ADDR_W-1:0] : '0;
    assign regceb = 1'b1;
    assign rstb   = ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_reg  <= '0;
            last_sr_reg <= '0;
        end else begin
            vld_sr_reg[0]  <= issue;
            last_sr_reg[0] <= issue && (rd_addr_reg == RD_LAST);
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr_reg[i]  <= vld_sr_reg[i-1];
                last_sr_reg[i] <= last_sr_reg[i-1];
            end
        end
    end

    fb_out_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_sr_reg[RD_LAT-1]),
        .din   ({last_sr_reg[RD_LAT-1], doutb}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign m_valid  = !rst && fifo_valid;
    assign m_data   = fifo_dout[DATA_W-1:0];
    assign m_last   = m_valid && fifo_dout[DATA_W];
    assign pop      = m_valid && m_ready;
    assign last_pop = pop && fifo_dout[DATA_W];

    // ---------------- control ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept && s_sof) state_next = ST_WRITE;
            ST_WRITE: if (wr_last)         state_next = ST_FULL;
            ST_FULL:  if (rd_start)        state_next = ST_READ;
            ST_READ:  if (last_pop)        state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wr_addr_reg    <= '0;
            rd_addr_reg    <= '0;
            frame_done_reg <= 1'b0;
            rd_done_reg    <= 1'b0;
            sof_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= wr_last;
            sof_err_reg    <= (state_reg == ST_WRITE) && accept && s_sof;
            rd_done_reg    <= (state_reg == ST_READ) && last_pop;

            if (wr_en && wr_to_zero) begin
                wr_addr_reg <= ONE_A;
            end else if (wr_en) begin
                wr_addr_reg <= wr_last ? '0 : (wr_addr_reg + ONE_A);
            end

            if ((state_reg == ST_FULL) && rd_start) begin
                rd_addr_reg <= '0;
            end else if (last_pop) begin
                rd_addr_reg <= '0;
            end else if (issue) begin
                rd_addr_reg <= rd_addr_reg + ONE_R;
            end
        end
    end

    assign frame_done = !rst && frame_done_reg;
    assign rd_done    = !rst && rd_done_reg;
    assign sof_err    = !rst && sof_err_reg;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl on a reduced 40-pixel frame with a
// behavioural two-port BRAM and write/read scoreboards.
module tb_frame_buf_ctrl;
    import fb_pkg::*;

    localparam int DW = 8;
    localparam int FP = 40;
    localparam int AW = 6;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_sof;
    logic          rd_start;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          ena, wea, enb, web, regceb, rstb;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina;
    logic [DW-1:0] doutb;
    logic          frame_done, rd_done, sof_err;

    always #5 clk = ~clk;

    frame_buf_ctrl #(
        .DATA_W       (DW),
        .FRAME_PIXELS (FP),
        .ADDR_W       (AW),
        .RD_LAT       (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .rd_start   (rd_start),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .ena        (ena),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .enb        (enb),
        .web        (web),
        .addrb      (addrb),
        .regceb     (regceb),
        .rstb       (rstb),
        .doutb      (doutb),
        .frame_done (frame_done),
        .rd_done    (rd_done),
        .sof_err    (sof_err)
    );

    // Behavioural BRAM: port A write, port B read with RL-cycle latency.
    logic [DW-1:0] bram    [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:RL-1];

    always @(posedge clk) begin
        if (ena && wea) bram[addra] <= dina;
        if (enb) rd_pipe[0] <= bram[addrb];
        for (int i = 1; i < RL; i++) begin
            if (regceb) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign doutb = rd_pipe[RL-1];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } rd_t;

    wr_t           wr_q[$];
    rd_t           rd_q[$];
    logic [DW-1:0] frame_img [0:FP-1];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int issued = 0;
    int pops = 0;
    int fd_cnt = 0;
    bit stall_seen = 0;
    bit hold_pending = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples all DUT activity mid-cycle and checks it against the scoreboards.
    task automatic monitor();
        wr_t w;
        rd_t r;
        int  outstanding;
        if (ena && wea) begin
            chk("wr_expected", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                chk("wr_addr", 32'(addra), 32'(w.addr));
                chk("wr_data", 32'(dina), 32'(w.data));
            end
        end
        if (frame_done) fd_cnt++;
        if (hold_pending) chk("m_valid_hold", 32'(m_valid), 1);
        hold_pending = m_valid && !m_ready && !rst;
        if (!rst && (dut.state_reg == ST_READ)) begin
            outstanding = issued - pops;
            chk("outstanding_le4", 32'(outstanding <= 4), 1);
            if (outstanding == 4) begin
                stall_seen = 1;
                chk("enb_stall", 32'(enb), 0);
            end
        end
        if (enb) begin
            chk("rd_addr_seq", 32'(addrb), 32'(issued));
            issued++;
        end
        if (m_valid && m_ready) begin
            chk("rd_expected", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) begin
                r = rd_q.pop_front();
                chk("m_data", 32'(m_data), 32'(r.data));
                chk("m_last", 32'(m_last), 32'(r.last));
            end
            pops++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic sof, input int exp_addr);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        if (exp_addr >= 0) begin
            wr_q.push_back(wr_t'{addr: AW'(exp_addr), data: d});
            frame_img[exp_addr] = d;
        end
        #1;
        chk("beat_wea", 32'(wea), 32'(exp_addr >= 0));
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
    endtask

    // Frame starting with s_sof beat d0, pixel i = i*mul+add for i>0.
    task automatic write_frame(input logic [DW-1:0] d0, input int mul, input int add, input bit exp_err);
        int fd0;
        fd0 = fd_cnt;
        beat(d0, 1'b1, 0);
        chk("sof_err_after_sof", 32'(sof_err), 32'(exp_err));
        chk("state_write", 32'(dut.state_reg), 32'(ST_WRITE));
        for (int i = 1; i < FP; i++) begin
            if (i == 2) chk("sof_err_one_pulse", 32'(sof_err), 0);
            if (i == FP - 1) chk("no_early_done", 32'(fd_cnt), 32'(fd0));
            beat(DW'(i * mul + add), 1'b0, i);
        end
        chk("frame_done_pulse", 32'(frame_done), 1);
        chk("state_full", 32'(dut.state_reg), 32'(ST_FULL));
        chk("s_ready_full", 32'(s_ready), 0);
        chk("wr_q_drained", 32'(wr_q.size()), 0);
        tick();
        chk("frame_done_once", 32'(fd_cnt), 32'(fd0 + 1));
        chk("frame_done_low", 32'(frame_done), 0);
    endtask

    task automatic read_frame(input bit rand_ready);
        int lat;
        int gaps;
        int t0;
        int guard;
        issued = 0;
        pops = 0;
        stall_seen = 0;
        for (int i = 0; i < FP; i++) begin
            rd_q.push_back(rd_t'{data: frame_img[i], last: (i == FP - 1)});
        end
        m_ready  = !rand_ready;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("state_read", 32'(dut.state_reg), 32'(ST_READ));
        if (!rand_ready) begin
            lat = 0;
            while (!m_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk("first_valid_latency", 32'(lat), 32'(RL + 1));
            gaps = 0;
            t0 = cyc;
            while (rd_q.size() != 0 && (cyc - t0) < 4 * FP) begin
                if (!m_valid) gaps++;
                tick();
            end
            chk("sustained_gaps", 32'(gaps), 0);
            chk("sustained_cycles", 32'(cyc - t0), 32'(FP));
        end else begin
            guard = 0;
            while (rd_q.size() != 0 && guard < 40 * FP) begin
                m_ready = ($urandom_range(0, 9) < 3);
                tick();
                guard++;
            end
            chk("stall_seen", 32'(stall_seen), 1);
        end
        chk("rd_q_drained", 32'(rd_q.size()), 0);
        chk("pop_count", 32'(pops), 32'(FP));
        chk("rd_done_pulse", 32'(rd_done), 1);
        chk("idle_after_read", 32'(dut.state_reg), 32'(ST_IDLE));
        m_ready = 1'b0;
        tick();
        chk("rd_done_low", 32'(rd_done), 0);
    endtask

    initial begin
        int guard;
        // Reset with aggressive inputs that must all be ignored.
        rst      = 1'b1;
        s_valid  = 1'b1;
        s_sof    = 1'b1;
        s_data   = 8'h5A;
        rd_start = 1'b1;
        m_ready  = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_ena", 32'(ena), 0);
        chk("rst_wea", 32'(wea), 0);
        chk("rst_enb", 32'(enb), 0);
        chk("rst_web", 32'(web), 0);
        chk("rst_addra", 32'(addra), 0);
        chk("rst_addrb", 32'(addrb), 0);
        chk("rst_dina", 32'(dina), 0);
        chk("rst_rstb", 32'(rstb), 0);
        chk("rst_regceb", 32'(regceb), 1);
        chk("rst_pulses", 32'({frame_done, rd_done, sof_err}), 0);
        rst      = 1'b0;
        s_valid  = 1'b0;
        s_sof    = 1'b0;
        s_data   = '0;
        rd_start = 1'b0;
        m_ready  = 1'b0;
        tick();
        chk("idle_after_rst", 32'(dut.state_reg), 32'(ST_IDLE));
        chk("idle_s_ready", 32'(s_ready), 1);
        chk("rstb_released", 32'(rstb), 1);

        // IDLE: non-sof beats discarded, rd_start ignored.
        for (int i = 0; i < 5; i++) beat(DW'(8'hC0 + i), 1'b0, -1);
        chk("idle_stays", 32'(dut.state_reg), 32'(ST_IDLE));
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("idle_rd_start_ignored", 32'(dut.state_reg), 32'(ST_IDLE));

        // Partial frame, then a restart mid-frame which must flag sof_err.
        beat(8'h11, 1'b1, 0);
        chk("first_sof_no_err", 32'(sof_err), 0);
        for (int i = 1; i < 10; i++) beat(DW'(8'h20 + i), 1'b0, i);
        write_frame(8'hA5, 1, 8'hA5, 1'b1);

        // FULL: input back-pressured, nothing written.
        s_valid = 1'b1;
        s_sof   = 1'b1;
        #1;
        chk("full_no_ena", 32'(ena), 0);
        chk("full_s_ready", 32'(s_ready), 0);
        tick();
        s_valid = 1'b0;
        s_sof   = 1'b0;
        chk("full_stays", 32'(dut.state_reg), 32'(ST_FULL));

        read_frame(1'b0);

        write_frame(8'h3E, 13, 7, 1'b0);
        read_frame(1'b1);

        // Reset in the middle of a readout.
        write_frame(8'h81, 3, 8'h3C, 1'b0);
        issued = 0;
        pops = 0;
        for (int i = 0; i < FP; i++) begin
            rd_q.push_back(rd_t'{data: frame_img[i], last: (i == FP - 1)});
        end
        m_ready  = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        guard = 0;
        while (pops < 20 && guard < 100) begin
            tick();
            guard++;
        end
        chk("pops_before_rst", 32'(pops), 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_state", 32'(dut.state_reg), 32'(ST_IDLE));
        chk("midrst_fifo_empty", 32'(dut.u_fifo.count_reg), 0);
        rd_q.delete();
        issued = 0;
        pops = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("midrst_rd_start_ignored", 32'(dut.state_reg), 32'(ST_IDLE));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_quiet", 32'({m_valid, enb}), 0);
        end

        write_frame(8'h77, 5, 1, 1'b0);
        read_frame(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
